// File: rtl/second_chance_flags.sv
// Valid/ref flag table with NUM_RD registered read ports and a clock-hand
// (second chance) victim search. Define SECOND_CHANCE_FLAGS_BYPASS_EN for write-first reads.
module second_chance_flags #(
  parameter int ADR_W  = 10,
  parameter int NUM_RD = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_RD*ADR_W-1:0] rd_adr,
  output logic [NUM_RD-1:0]       rd_valid,
  output logic [NUM_RD-1:0]       rd_ref,
  input  logic                    wr_en,
  input  logic [ADR_W-1:0]        wr_adr,
  input  logic                    wr_valid,
  input  logic                    touch_en,
  input  logic [ADR_W-1:0]        touch_adr,
  input  logic                    clear_all,
  input  logic                    victim_req,
  output logic                    victim_busy,
  output logic                    victim_done,
  output logic [ADR_W-1:0]        victim_adr
);

  localparam int DEPTH = 2**ADR_W;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DEPTH-1:0]   r_valid;
  logic [DEPTH-1:0]   r_ref;
  logic [ADR_W-1:0]   r_hand;
  logic               w_scan;
  logic               w_found;
  logic               w_clear_ref;
  logic [NUM_RD-1:0]  w_rd_valid;
  logic [NUM_RD-1:0]  w_rd_ref;

  // NOTE: sequential state uses non-blocking assignments so every process sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    if (clear_all) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (victim_req) w_state_nxt = SCAN;
        SCAN:    if (w_found)    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Scan decision on the entry under the hand, from pre-edge flags.
  always_comb begin
    w_scan      = (r_state == SCAN) && !clear_all;
    w_found     = w_scan && (!r_valid[r_hand] || !r_ref[r_hand]);
    w_clear_ref = w_scan && !w_found;
    victim_busy = (r_state == SCAN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hand      <= '0;
      victim_done <= 1'b0;
      victim_adr  <= '0;
    end else begin
      victim_done <= w_found;
      if (clear_all) begin
        r_hand <= '0;
      end else if (w_scan) begin
        r_hand <= r_hand + 1'b1;
      end
      if (w_found) begin
        victim_adr <= r_hand;
      end
    end
  end

  // NOTE: the flag table is kept in flops with an async reset (not a RAM) because the whole
  // table must clear on reset and in a single cycle on clear_all.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_ref   <= '0;
    end else if (clear_all) begin
      r_valid <= '0;
      r_ref   <= '0;
    end else begin
      // NOTE: the last non-blocking assignment wins, so order gives write > touch > scan clear.
      if (w_clear_ref) begin
        r_ref[r_hand] <= 1'b0;
      end
      if (touch_en && r_valid[touch_adr]) begin
        r_ref[touch_adr] <= 1'b1;
      end
      if (wr_en) begin
        r_valid[wr_adr] <= wr_valid;
        r_ref[wr_adr]   <= wr_valid;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADR_W-1:0] w_adr;
    assign w_adr = rd_adr[gi*ADR_W +: ADR_W];
`ifdef SECOND_CHANCE_FLAGS_BYPASS_EN
    logic w_wr_hit;
    logic w_touch_hit;
    assign w_wr_hit    = wr_en && (wr_adr == w_adr);
    assign w_touch_hit = touch_en && (touch_adr == w_adr);
    assign w_rd_valid[gi] = clear_all ? 1'b0 :
                            w_wr_hit  ? wr_valid : r_valid[w_adr];
    assign w_rd_ref[gi]   = clear_all   ? 1'b0 :
                            w_wr_hit    ? wr_valid :
                            w_touch_hit ? (r_ref[w_adr] | r_valid[w_adr]) : r_ref[w_adr];
`else
    assign w_rd_valid[gi] = r_valid[w_adr];
    assign w_rd_ref[gi]   = r_ref[w_adr];
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= '0;
      rd_ref   <= '0;
    end else begin
      rd_valid <= w_rd_valid;
      rd_ref   <= w_rd_ref;
    end
  end

endmodule
